vectorsum_ctrl: RTL and testbench

Host-side companion to the vectorsum datapath.
- Drains two input FIFOs into the x and y BRAM write ports.
- Pulses start to vectorsum and waits for its done.
- Reads the z BRAM and streams the results into an output FIFO.
- Sits at the top level between the FIFOs, the three BRAMs and vectorsum; it writes what vectorsum reads and reads what vectorsum writes.

---
 rtl/vectorsum_pkg.sv | 7 +
 rtl/vectorsum_ctrl.sv | 96 +++++++++
 tb/tb_vectorsum_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vectorsum_pkg.sv
// vectorsum_pkg: shared FSM state type and default sizes for vectorsum and its controller
package vectorsum_pkg;
   localparam int VS_DATA_WIDTH  = 32;
   localparam int VS_ADDR_WIDTH  = 10;
   localparam int VS_VECTOR_SIZE = 1024;
   typedef enum logic [2:0] {S_LOAD, S_START, S_WAIT, S_ZRD, S_ZOUT} state_t;
endpackage

// File: rtl/vectorsum_ctrl.sv
// vectorsum_ctrl: loads x/y BRAMs from paired FIFOs, kicks vectorsum, streams z BRAM to the output FIFO
// ports: clock/reset (sync, active-high); x_in_*/y_in_* FWFT input FIFOs; x_*/y_* BRAM write ports;
//        vs_start/vs_done vectorsum handshake; z_addr/z_dout z BRAM read (1-cycle latency);
//        out_full/out_wr_en/out_din output FIFO; busy high unless idle in S_LOAD at index 0
module vectorsum_ctrl
   import vectorsum_pkg::*;
#(
   parameter int DATA_WIDTH  = VS_DATA_WIDTH,
   parameter int ADDR_WIDTH  = VS_ADDR_WIDTH,
   parameter int VECTOR_SIZE = VS_VECTOR_SIZE
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  x_in_empty,
   output logic                  x_in_rd_en,
   input  logic [DATA_WIDTH-1:0] x_in_dout,
   input  logic                  y_in_empty,
   output logic                  y_in_rd_en,
   input  logic [DATA_WIDTH-1:0] y_in_dout,
   output logic [DATA_WIDTH-1:0] x_din,
   output logic [ADDR_WIDTH-1:0] x_addr,
   output logic                  x_wr_en,
   output logic [DATA_WIDTH-1:0] y_din,
   output logic [ADDR_WIDTH-1:0] y_addr,
   output logic                  y_wr_en,
   output logic                  vs_start,
   input  logic                  vs_done,
   output logic [ADDR_WIDTH-1:0] z_addr,
   input  logic [DATA_WIDTH-1:0] z_dout,
   input  logic                  out_full,
   output logic                  out_wr_en,
   output logic [DATA_WIDTH-1:0] out_din,
   output logic                  busy
);
   // comparing against the last index keeps i from ever needing an extra bit
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VECTOR_SIZE - 1);
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] i_q, i_d;
   logic                  done_q, done_d;
   logic                  fire, last, ld, push;
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_LOAD;
         i_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         done_q  <= done_d;
      end
   end
   // a load fires only when both heads are present so x[i] and y[i] always pair
   always_comb begin
      fire    = state_q == S_LOAD && !x_in_empty && !y_in_empty;
      last    = i_q == LAST;
      state_d = state_q;
      i_d     = i_q;
      done_d  = done_q;
      unique case (state_q)
         S_LOAD: if (fire) begin
            i_d     = last ? '0 : i_q + 1'b1;
            state_d = last ? S_START : S_LOAD;
         end
         S_START: state_d = S_WAIT;
         // only a rising done counts; a level left over from the last run is ignored
         S_WAIT: begin
            done_d  = vs_done;
            state_d = vs_done && !done_q ? S_ZRD : S_WAIT;
         end
         S_ZRD: state_d = S_ZOUT;
         S_ZOUT: if (!out_full) begin
            i_d     = last ? '0 : i_q + 1'b1;
            state_d = last ? S_LOAD : S_ZRD;
         end
         default: state_d = S_LOAD;
      endcase
   end
   always_comb begin
      ld         = !reset && fire;
      push       = !reset && state_q == S_ZOUT && !out_full;
      x_in_rd_en = ld;
      y_in_rd_en = ld;
      x_wr_en    = ld;
      y_wr_en    = ld;
      x_addr     = ld ? i_q : '0;
      y_addr     = ld ? i_q : '0;
      x_din      = ld ? x_in_dout : '0;
      y_din      = ld ? y_in_dout : '0;
      vs_start   = !reset && state_q == S_START;
      // address held through S_ZOUT so z_dout stays stable under backpressure
      z_addr     = !reset && (state_q == S_ZRD || state_q == S_ZOUT) ? i_q : '0;
      out_wr_en  = push;
      out_din    = push ? z_dout : '0;
      busy       = !reset && !(state_q == S_LOAD && i_q == '0);
   end
endmodule

// File: tb/tb_vectorsum_ctrl.sv
// tb_vectorsum_ctrl: directed runs against a FIFO/BRAM/vectorsum environment with a per-cycle reference model
module tb_vectorsum_ctrl;
   localparam int DW = 32;
   localparam int AW = 2;
   localparam int N  = 4;
   localparam int P_LOAD = 0, P_START = 1, P_WAIT = 2, P_ISS = 3, P_OUT = 4;
   typedef struct {
      string       nm;
      logic [31:0] a;
      logic [31:0] e;
   } lit_t;
   logic          clock = 1'b0;
   logic          reset;
   logic          x_in_empty, x_in_rd_en, y_in_empty, y_in_rd_en;
   logic [DW-1:0] x_in_dout, y_in_dout, x_din, y_din, z_dout, out_din;
   logic [AW-1:0] x_addr, y_addr, z_addr;
   logic          x_wr_en, y_wr_en, vs_start, vs_done, out_full, out_wr_en, busy;
   logic [DW-1:0] xf[64], yf[64];
   int            xw = 0, yw = 0, xr = 0, yr = 0;
   logic [DW-1:0] xmem[N], ymem[N], zmem[N];
   logic [DW-1:0] got[256];
   int            gn = 0;
   logic          done_r = 1'b0, stale_force = 1'b0, z_valid = 1'b0, vs_run = 1'b0;
   int            vs_cnt = 0;
   int            checks = 0, errors = 0;
   lit_t          lq[$];
   lit_t          l;
   int            m_ph = P_LOAD, m_k = 0;
   logic          m_dq = 1'b0;
   logic [DW-1:0] mx[N], my[N];
   logic          fire, psh;
   logic [AW-1:0] e_addr, e_z;
   logic [DW-1:0] e_xd, e_yd, e_od;
   logic [108:0]  exp_v, act_v;

   vectorsum_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(N)) dut (
      .clock(clock), .reset(reset),
      .x_in_empty(x_in_empty), .x_in_rd_en(x_in_rd_en), .x_in_dout(x_in_dout),
      .y_in_empty(y_in_empty), .y_in_rd_en(y_in_rd_en), .y_in_dout(y_in_dout),
      .x_din(x_din), .x_addr(x_addr), .x_wr_en(x_wr_en),
      .y_din(y_din), .y_addr(y_addr), .y_wr_en(y_wr_en),
      .vs_start(vs_start), .vs_done(vs_done),
      .z_addr(z_addr), .z_dout(z_dout),
      .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din), .busy(busy)
   );

   always #5 clock = ~clock;
   assign x_in_empty = xw == xr;
   assign y_in_empty = yw == yr;
   assign x_in_dout  = xf[xr];
   assign y_in_dout  = yf[yr];
   assign vs_done    = done_r | stale_force;

   // FIFOs, BRAMs, output FIFO and a behavioural vectorsum (done falls after start, rises when z is ready)
   always @(posedge clock) begin
      if (x_in_rd_en) xr <= xr + 1;
      if (y_in_rd_en) yr <= yr + 1;
      if (x_wr_en) xmem[x_addr] <= x_din;
      if (y_wr_en) ymem[y_addr] <= y_din;
      z_dout <= zmem[z_addr];
      if (out_wr_en) begin
         got[gn] <= out_din;
         gn <= gn + 1;
      end
      if (vs_start) begin
         done_r  <= 1'b0;
         vs_run  <= 1'b1;
         vs_cnt  <= 8;
         z_valid <= 1'b0;
      end else if (vs_run) begin
         if (vs_cnt == 0) begin
            for (int k = 0; k < N; k++) zmem[k] <= xmem[k] + ymem[k];
            done_r  <= 1'b1;
            vs_run  <= 1'b0;
            z_valid <= 1'b1;
         end else vs_cnt <= vs_cnt - 1;
      end
   end

   // reference model: what every output must be this cycle, then advance to the next cycle
   always @(negedge clock) begin
      fire   = !reset && m_ph == P_LOAD && !x_in_empty && !y_in_empty;
      psh    = !reset && m_ph == P_OUT && !out_full;
      e_addr = fire ? AW'(m_k) : '0;
      e_xd   = fire ? x_in_dout : '0;
      e_yd   = fire ? y_in_dout : '0;
      e_z    = !reset && (m_ph == P_ISS || m_ph == P_OUT) ? AW'(m_k) : '0;
      e_od   = psh ? mx[m_k] + my[m_k] : '0;
      exp_v  = {fire, fire, fire, fire, e_addr, e_addr, e_xd, e_yd, !reset && m_ph == P_START,
                e_z, psh, e_od, !reset && !(m_ph == P_LOAD && m_k == 0)};
      act_v  = {x_in_rd_en, y_in_rd_en, x_wr_en, y_wr_en, x_addr, y_addr, x_din, y_din, vs_start,
                z_addr, out_wr_en, out_din, busy};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL cycle t=%0t outputs got %h want %h", $time, act_v, exp_v);
      end
      if (out_wr_en) begin
         checks++;
         if (!z_valid) begin
            errors++;
            $display("FAIL zvalid t=%0t push before vectorsum finished got %b want 1", $time, z_valid);
         end
      end
      while (lq.size() > 0) begin
         l = lq.pop_front();
         checks++;
         if (l.a !== l.e) begin
            errors++;
            $display("FAIL %s got %h want %h", l.nm, l.a, l.e);
         end
      end
      if (reset) begin
         m_ph = P_LOAD;
         m_k  = 0;
         m_dq = 1'b0;
      end else case (m_ph)
         P_LOAD: if (fire) begin
            mx[m_k] = x_in_dout;
            my[m_k] = y_in_dout;
            if (m_k == N - 1) begin m_k = 0; m_ph = P_START; end else m_k++;
         end
         P_START: m_ph = P_WAIT;
         P_WAIT: begin
            if (vs_done && !m_dq) m_ph = P_ISS;
            m_dq = vs_done;
         end
         P_ISS: m_ph = P_OUT;
         P_OUT: if (psh) begin
            if (m_k == N - 1) begin m_k = 0; m_ph = P_LOAD; end else begin m_k++; m_ph = P_ISS; end
         end
         default: m_ph = P_LOAD;
      endcase
   end

   task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
      lq.push_back('{nm, a, e});
   endtask
   task automatic push_x(input logic [31:0] v);
      xf[xw] = v;
      xw++;
   endtask
   task automatic push_y(input logic [31:0] v);
      yf[yw] = v;
      yw++;
   endtask
   task automatic push4(input logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3);
      push_x(x0); push_x(x1); push_x(x2); push_x(x3);
      push_y(y0); push_y(y1); push_y(y2); push_y(y3);
   endtask
   task automatic wait_out(input int n);
      int b = 0;
      while (gn < n && b < 400) begin
         @(posedge clock);
         #1;
         b++;
      end
   endtask
   task automatic check_run(input string nm, input int base, input logic [31:0] e0, e1, e2, e3);
      wait_out(base + 4);
      repeat (20) @(posedge clock);
      #1;
      lit({nm, "_count"}, gn, base + 4);
      lit({nm, "_z0"}, got[base], e0);
      lit({nm, "_z1"}, got[base + 1], e1);
      lit({nm, "_z2"}, got[base + 2], e2);
      lit({nm, "_z3"}, got[base + 3], e3);
   endtask

   initial begin
      int base, b;
      reset    = 1'b1;
      out_full = 1'b0;
      // basic run
      push4(1, 2, 3, 4, 10, 20, 30, 40);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check_run("basic", 0, 11, 22, 33, 44);
      // y trickles in: x must wait for its partner
      base = gn;
      push_x(1); push_x(2); push_x(3); push_x(4);
      for (int k = 1; k <= 4; k++) begin
         repeat (5) @(posedge clock);
         #1 push_y(10 * k);
      end
      check_run("trickle", base, 11, 22, 33, 44);
      // output backpressure while reading index 1
      base = gn;
      push4(2, 4, 6, 8, 1, 1, 1, 1);
      wait_out(base + 1);
      out_full = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      lit("hold_zaddr", 32'(z_addr), 1);
      lit("hold_count", gn, base + 1);
      repeat (2) @(posedge clock);
      #1 out_full = 1'b0;
      check_run("bp", base, 3, 5, 7, 9);
      // stale done level held across the start
      base = gn;
      stale_force = 1'b1;
      push4(100, 200, 300, 400, 5, 6, 7, 8);
      b = 0;
      while (!vs_start && b < 400) begin
         @(negedge clock);
         b++;
      end
      repeat (4) @(posedge clock);
      #1;
      lit("stale_hold", gn, base);
      stale_force = 1'b0;
      check_run("stale", base, 105, 206, 307, 408);
      // reset after two loads discards the partial vector
      base = gn;
      push_x(5); push_x(6); push_y(50); push_y(60);
      b = 0;
      while (xr != xw && b < 100) begin
         @(posedge clock);
         #1;
         b++;
      end
      lit("partial_loaded", xr, xw);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      push4(9, 10, 11, 12, 90, 100, 110, 120);
      check_run("rst", base, 99, 110, 121, 132);
      // sums wrap modulo 2**32
      base = gn;
      push4(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 5, 1, 1, 0, 6);
      check_run("wrap", base, 32'h8000_0000, 0, 0, 11);
      repeat (3) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
